pm_loader: RTL and testbench
============================

# pm_loader

Serial program-memory loader for the 4-bit micro. It receives a framed bit-serial image and writes each byte into program memory through that memory's write port. It holds the CPU in reset while loading and releases it after a successful load. It is the writer side of the program-memory interface, which the program sequencer otherwise only reads.

## Interface
- ADDR_BASE, 8'h00, first program-memory address written by a load
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high; same polarity and timing as the micro's reset
- ld_start  in  1  one-cycle pulse; begins (or restarts) a load
- ser_strobe  in  1  qualifies ser_bit; one bit accepted per cycle with strobe high
- ser_bit  in  1  serial data, MSB first
- pm_wr_addr  out  8  program-memory write address
- pm_wr_data  out  8  program-memory write data
- pm_wren  out  1  program-memory write enable, one-cycle pulse per byte
- cpu_reset  out  1  OR'd into the micro's reset; high while loading or errored
- busy  out  1  high in HDR/DATA/CSUM
- done  out  1  level; last load completed successfully
- error  out  1  level; last load failed checksum

## Operation
- States: IDLE, HDR, DATA, CSUM, DONE, ERR.
- Reset:
  - state=IDLE; all outputs 0.
  - Shift register and bit counter cleared; byte counter cleared; checksum accumulator cleared.
  - pm_wr_addr=ADDR_BASE.
- ld_start in any state:
  - Go to HDR.
  - Clear bit counter, checksum, done and error; pm_wr_addr=ADDR_BASE.
  - Set cpu_reset=1.
- Byte assembly:
  - Each ser_strobe shifts ser_bit into an 8-bit shift register LSB side, so the first bit ends up as the MSB.
  - A 3-bit counter counts strobes; the byte is complete on the 8th strobe and the counter wraps to 0.
- HDR:
  - Completed byte is the count N, loaded into the byte counter.
  - N=0 means 256 bytes. Go to DATA.
- DATA:
  - Each completed byte drives pm_wr_data, pm_wren=1 and checksum += byte (mod 256), then the byte counter decrements.
  - pm_wr_addr increments by 1 after each write and wraps 0xFF to 0x00.
  - After the N-th byte, go to CSUM (macro defined) or DONE (macro undefined).
- CSUM:
  - Completed byte is added to the accumulator.
  - Sum == 8'h00: go to DONE. Otherwise go to ERR.
- DONE: done=1, cpu_reset=0, busy=0. Hold until ld_start or reset.
- ERR: error=1, cpu_reset=1, busy=0. Hold until ld_start or reset.
- ser_strobe in IDLE/DONE/ERR is ignored; the bit counter does not advance.
- ld_start and ser_strobe in the same cycle: ld_start wins and the bit is discarded.
- Reset mid-load: immediate return to IDLE with cpu_reset=0. Any partial memory contents are left as written.

## Timing
- pm_wren, pm_wr_addr and pm_wr_data are registered.
- pm_wren is high exactly in the cycle after the rising edge that samples the 8th bit of a data byte.
  - pm_wr_addr/pm_wr_data are stable for that whole cycle.
  - Program memory clocks on ~clk, so it captures the write at the mid-cycle falling edge.
- pm_wr_addr increments on the rising edge that ends the pm_wren cycle.
- Strobes may arrive on consecutive cycles; the minimum byte time is 8 cycles, so back-to-back writes are spaced at least 8 cycles apart.
- cpu_reset rises the cycle after ld_start is sampled.
- cpu_reset falls the cycle after the final byte is sampled: the checksum byte, or the last data byte with the macro undefined.
- done/error are asserted in that same cycle.
- Load latency for N bytes: (N+2)·8 strobes with the macro defined, (N+1)·8 without.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - A checksum byte follows the data.
  - The two's-complement check (data sum + checksum == 0) is enforced.
  - ERR is reachable.
- LOADER_CHECKSUM_EN undefined:
  - No CSUM state and no checksum accumulator.
  - DATA goes straight to DONE; error is tied to 0.

## Test plan
- Reset, then idle with strobes toggling -> all outputs 0, no pm_wren, state IDLE.
- ld_start, then header 8'h02, data 8'h12, 8'h34, checksum 8'hBA:
  - pm_wren pulses twice: (addr 0x00, data 0x12) and (addr 0x01, data 0x34).
  - Then done=1, cpu_reset=0.
- Same stream with checksum 8'hBB -> two writes, then error=1, cpu_reset=1, done=0.
- Header 8'h00 with 256 incrementing bytes (macro undefined):
  - 256 writes, addresses 0x00..0xFF, with the address wrapping to 0x00.
  - Then done=1.
- ld_start asserted after 5 bits of the second data byte:
  - Restarts in HDR with address 0x00 and cpu_reset held 1.
  - The following full frame loads correctly.
- Reset asserted during DATA -> next cycle state IDLE, cpu_reset=0, busy=0, no further pm_wren.

Source files
------------

// File: rtl/pm_loader_if.sv
// Serial-load and program-memory write-port bundle for pm_loader.
// master: the loader (drives the write port and status); slave: host and memory side.
interface pm_loader_if;
  logic       ld_start;
  logic       ser_strobe;
  logic       ser_bit;
  logic [7:0] pm_wr_addr;
  logic [7:0] pm_wr_data;
  logic       pm_wren;
  logic       cpu_reset;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  ld_start, ser_strobe, ser_bit,
    output pm_wr_addr, pm_wr_data, pm_wren, cpu_reset, busy, done, error
  );

  modport slave (
    output ld_start, ser_strobe, ser_bit,
    input  pm_wr_addr, pm_wr_data, pm_wren, cpu_reset, busy, done, error
  );
endinterface

// File: rtl/pm_loader.sv
// Serial program-memory loader: framed MSB-first image -> program-memory write port.
// Optional LOADER_CHECKSUM_EN adds a trailing two's-complement checksum byte and the ERR state.
module pm_loader #(
  parameter logic [7:0] ADDR_BASE = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  pm_loader_if.master bus
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE} state_t;
`endif

  state_t     state, state_d;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [8:0] byte_cnt;   // 9 bits so a header of 0 can stand for 256
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wren;
  logic       cpu_reset_q;
  logic       done_q;
  logic       busy_w;
  logic       accept;
  logic       byte_done;
  logic [7:0] shift_d;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_sum;
  logic       error_q;
`endif

  always_comb begin
    busy_w = (state == HDR) || (state == DATA);
`ifdef LOADER_CHECKSUM_EN
    if (state == CSUM) busy_w = 1'b1;
`endif
  end

  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // left one unassigned would infer a latch.
    state_d   = state;
    shift_d   = {shreg[6:0], bus.ser_bit};
    accept    = bus.ser_strobe && busy_w;
    byte_done = accept && (bit_cnt == 3'd7);
`ifdef LOADER_CHECKSUM_EN
    csum_sum  = csum + shift_d;
`endif
    if (bus.ld_start) begin
      state_d = HDR;
    end else if (byte_done) begin
      case (state)
        HDR:  state_d = DATA;
        DATA: begin
          if (byte_cnt == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: state_d = (csum_sum == 8'h00) ? DONE : ERR;
`endif
        default: state_d = state;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 9'd0;
      wr_addr     <= ADDR_BASE;
      wr_data     <= 8'h00;
      wren        <= 1'b0;
      cpu_reset_q <= 1'b0;
      done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= 8'h00;
      error_q     <= 1'b0;
`endif
    end else begin
      wren        <= 1'b0;
      done_q      <= (state_d == DONE);
      cpu_reset_q <= (state_d != IDLE) && (state_d != DONE);
`ifdef LOADER_CHECKSUM_EN
      error_q     <= (state_d == ERR);
`endif
      // Address advances on the edge that closes the write-enable cycle.
      if (wren) wr_addr <= wr_addr + 8'd1;

      if (bus.ld_start) begin
        shreg   <= 8'h00;
        bit_cnt <= 3'd0;
        wr_addr <= ADDR_BASE;
`ifdef LOADER_CHECKSUM_EN
        csum    <= 8'h00;
`endif
      end else if (accept) begin
        shreg   <= shift_d;
        bit_cnt <= bit_cnt + 3'd1;
        if (byte_done) begin
          if (state == HDR) begin
            byte_cnt <= (shift_d == 8'h00) ? 9'd256 : {1'b0, shift_d};
          end else if (state == DATA) begin
            wr_data  <= shift_d;
            wren     <= 1'b1;
            byte_cnt <= byte_cnt - 9'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum + shift_d;
          end else if (state == CSUM) begin
            csum     <= csum_sum;
`endif
          end
        end
      end
    end
  end

  assign bus.pm_wr_addr = wr_addr;
  assign bus.pm_wr_data = wr_data;
  assign bus.pm_wren    = wren;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.busy       = busy_w;
  assign bus.done       = done_q;
`ifdef LOADER_CHECKSUM_EN
  assign bus.error      = error_q;
`else
  assign bus.error      = 1'b0;
`endif

endmodule

// File: tb/tb_pm_loader.sv
// Randomized bench for pm_loader against a frame-level reference model.
// Honours LOADER_CHECKSUM_EN the same way the design does.
module tb_pm_loader;
  localparam logic [7:0] ADDR_BASE = 8'h00;

  logic clk = 1'b0;
  logic reset;
  pm_loader_if bus ();

  pm_loader #(.ADDR_BASE(ADDR_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wren_cnt = 0;
  logic [15:0] wr_q[$];

  always @(negedge clk) begin
    if (bus.pm_wren === 1'b1) begin
      wr_q.push_back({bus.pm_wr_addr, bus.pm_wr_data});
      wren_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.ser_strobe = 1'b0;
    repeat (n) tick();
  endtask

  // Shifts one byte MSB first; returns one cycle after the edge sampling bit 0.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.ser_strobe = 1'b1;
      bus.ser_bit    = b[i];
      tick();
      bus.ser_strobe = 1'b0;
      bus.ser_bit    = 1'($urandom);
      if (i != 0) repeat ($urandom_range(0, 1)) tick();
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.ser_strobe = 1'b1;
      bus.ser_bit    = b[i];
      tick();
    end
    bus.ser_strobe = 1'b0;
  endtask

  task automatic start_load(input logic with_strobe);
    bus.ld_start   = 1'b1;
    bus.ser_strobe = with_strobe;
    bus.ser_bit    = 1'b1;
    tick();
    bus.ld_start   = 1'b0;
    bus.ser_strobe = 1'b0;
    wr_q.delete();
    check("start_cpu_reset", bus.cpu_reset, 1);
    check("start_busy", bus.busy, 1);
    check("start_done", bus.done, 0);
    check("start_error", bus.error, 0);
    check("start_addr", bus.pm_wr_addr, ADDR_BASE);
  endtask

  // Reference: byte i lands at ADDR_BASE+i mod 256; load succeeds iff sum+ck == 0 mod 256.
  task automatic do_frame(input logic [7:0] hdr, input logic [7:0] data[$], input logic [7:0] ck);
    int n;
    int sum;
    bit ok;
    n   = (hdr == 8'h00) ? 256 : int'(hdr);
    sum = 0;
    send_byte(hdr);
    check("hdr_no_wren", bus.pm_wren, 0);
    for (int i = 0; i < n; i++) begin
      send_byte(data[i]);
      sum += int'(data[i]);
      check("wr_en", bus.pm_wren, 1);
      check("wr_data", bus.pm_wr_data, data[i]);
      check("wr_addr", bus.pm_wr_addr, (int'(ADDR_BASE) + i) % 256);
      if (i == 0) check("busy_in_data", bus.busy, 1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(ck);
    ok = ((sum + int'(ck)) % 256) == 0;
`else
    ok = 1'b1;
`endif
    check("end_done", bus.done, ok);
    check("end_error", bus.error, !ok);
    check("end_cpu_reset", bus.cpu_reset, !ok);
    check("end_busy", bus.busy, 0);
    idle(3);
    check("write_count", wr_q.size(), n);
    check("final_addr", bus.pm_wr_addr, (int'(ADDR_BASE) + n) % 256);
    check("hold_done", bus.done, ok);
  endtask

  function automatic logic [7:0] good_ck(input logic [7:0] data[$]);
    int s = 0;
    foreach (data[i]) s += int'(data[i]);
    return 8'((256 - (s % 256)) % 256);
  endfunction

  initial begin
    logic [7:0] d[$];
    logic [7:0] hdr;
    logic [7:0] ck;
    int snap;

    bus.ld_start = 1'b0; bus.ser_strobe = 1'b0; bus.ser_bit = 1'b0;
    reset = 1'b1;
    repeat (3) begin bus.ser_strobe = ~bus.ser_strobe; tick(); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.ser_strobe = 1'(i % 2);
      bus.ser_bit    = 1'($urandom);
      tick();
    end
    bus.ser_strobe = 1'b0;
    check("rst_wren_count", wren_cnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cpu_reset", bus.cpu_reset, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_addr", bus.pm_wr_addr, ADDR_BASE);

    // Directed frame with a correct checksum.
    d = '{8'h12, 8'h34};
    start_load(1'b0);
    do_frame(8'h02, d, 8'hBA);
`ifdef LOADER_CHECKSUM_EN
    start_load(1'b0);
    do_frame(8'h02, d, 8'hBB);
`endif

    // Header 0 means 256 bytes; address wraps back to base.
    d.delete();
    for (int i = 0; i < 256; i++) d.push_back(8'(i));
    start_load(1'b0);
    do_frame(8'h00, d, good_ck(d));

    // Restart after 5 bits of the second data byte, with a strobe in the same cycle.
    start_load(1'b0);
    send_byte(8'h03);
    send_byte(8'hA5);
    send_bits(8'hFF, 5);
    start_load(1'b1);
    d = '{8'h5A, 8'hC3, 8'h0F};
    do_frame(8'h03, d, good_ck(d));

    // Random frames, sometimes with a corrupted checksum.
    for (int f = 0; f < 6; f++) begin
      hdr = 8'($urandom_range(1, 24));
      d.delete();
      for (int i = 0; i < int'(hdr); i++) d.push_back(8'($urandom));
      ck = good_ck(d);
      if ($urandom_range(0, 1) == 1) ck = ck + 8'($urandom_range(1, 255));
      start_load(1'b0);
      do_frame(hdr, d, ck);
    end

    // Reset in the middle of DATA.
    start_load(1'b0);
    send_byte(8'h05);
    send_byte(8'h11);
    send_byte(8'h22);
    send_bits(8'hE0, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    snap = wren_cnt;
    check("midrst_busy", bus.busy, 0);
    check("midrst_cpu_reset", bus.cpu_reset, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_wren", bus.pm_wren, 0);
    check("midrst_addr", bus.pm_wr_addr, ADDR_BASE);
    for (int i = 0; i < 24; i++) begin
      bus.ser_strobe = 1'b1;
      bus.ser_bit    = 1'($urandom);
      tick();
    end
    bus.ser_strobe = 1'b0;
    idle(2);
    check("midrst_no_writes", wren_cnt, snap);
    check("midrst_still_idle", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
